// File: rtl/sort_pkg.sv
// ----------------------------------------------------------------------------
// sort_pkg
//
// Shared definitions for the bubble-sort subsystem: default element width,
// address width and depth (also used by the controller's datapath), and the
// state encoding of the host-side loader/unloader (sort_host_if).
// ----------------------------------------------------------------------------
package sort_pkg;

    // Default geometry shared by the host interface and the sort datapath.
    localparam int unsigned SORT_DATA_W = 8;
    localparam int unsigned SORT_ADDR_W = 4;
    localparam int unsigned SORT_DEPTH  = 16;

    // Host interface phases:
    //   StLoad - accept unsorted words and write them into the sort memory
    //   StSort - hand the memory to the controller and wait for it to finish
    //   StRd   - issue a read of the next sorted word
    //   StCap  - capture the read data into the output register
    //   StOut  - present the word until the consumer accepts it
    typedef enum logic [2:0] {
        StLoad,
        StSort,
        StRd,
        StCap,
        StOut
    } sort_host_state_t;

endpackage

// File: rtl/sort_host_ptr.sv
// ----------------------------------------------------------------------------
// sort_host_ptr
//
// Pointer bank for sort_host_if: the load-side write pointer, the drain-side
// read pointer and the captured element count n_len. All registers reset
// synchronously to zero.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   wr_clr  in   clear wr_ptr (takes priority over wr_inc)
//   wr_inc  in   increment wr_ptr (wraps at 2^ADDR_W)
//   rd_clr  in   clear rd_ptr (takes priority over rd_inc)
//   rd_inc  in   increment rd_ptr
//   n_cap   in   load n_len with wr_ptr + 1 (count including the word being
//                written this cycle)
//   wr_ptr  out  current write address
//   rd_ptr  out  current read address
//   n_len   out  element count, one bit wider than the address so that a
//                full memory of 2^ADDR_W words is representable
// ----------------------------------------------------------------------------
module sort_host_ptr
    import sort_pkg::*;
#(
    parameter int unsigned ADDR_W = SORT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_clr,
    input  logic              wr_inc,
    input  logic              rd_clr,
    input  logic              rd_inc,
    input  logic              n_cap,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]   n_len
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   n_len_q,  n_len_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        n_len_d  = n_len_q;

        if (wr_clr) begin
            wr_ptr_d = '0;
        end else if (wr_inc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        if (rd_clr) begin
            rd_ptr_d = '0;
        end else if (rd_inc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        // Zero-extend before adding so that the DEPTH-th word (wr_ptr at its
        // maximum) yields 2^ADDR_W rather than wrapping to zero.
        if (n_cap) begin
            n_len_d = {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            n_len_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            n_len_q  <= n_len_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign n_len  = n_len_q;

endmodule

// File: rtl/sort_host_if.sv
// ----------------------------------------------------------------------------
// sort_host_if
//
// Host-side loader/unloader for the bubble-sort controller. Unsorted words
// arrive on a valid/ready stream and are written into the sort memory. The
// set ends on a word flagged in_last or on the DEPTH-th word; the block then
// raises start to the controller and releases the memory port (mem_sel = 0)
// until the controller reports done. Sorted words are then read back one at a
// time (read, capture, present) and streamed out with out_last on the final
// word, after which the block returns to loading.
//
// done is the controller's preset level, which can still be high from the
// previous run when sorting begins. The sort phase only ends on a high done
// after done has been seen low at least once in this sort phase.
//
// Parameters:
//   DATA_W  element width
//   ADDR_W  memory address width
//   DEPTH   maximum element count (must not exceed 2^ADDR_W)
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   input element valid
//   in_ready     out  block can accept an element (only while loading)
//   in_data      in   input element
//   in_last      in   final element of the set
//   out_valid    out  sorted element valid
//   out_ready    in   consumer accepts
//   out_data     out  sorted element
//   out_last     out  final sorted element
//   start        out  to the controller's start (high for the whole sort phase)
//   done         in   from the controller's preset
//   n_len        out  element count for the datapath N register
//   mem_sel      out  1 = this block owns the memory port, 0 = controller
//   mem_addr     out  memory address
//   mem_we       out  write strobe
//   mem_wdata    out  write data
//   mem_rd       out  read strobe
//   mem_rdata    in   read data, valid the cycle after mem_rd
//   sort_cycles  out  (only with SORT_HOST_PERF_EN) cycles spent in the last
//                     or current sort phase, saturating at 16'hFFFF
//
// Build option: define SORT_HOST_PERF_EN to add the sort_cycles counter/port.
// ----------------------------------------------------------------------------
module sort_host_if
    import sort_pkg::*;
#(
    parameter int unsigned DATA_W = SORT_DATA_W,
    parameter int unsigned ADDR_W = SORT_ADDR_W,
    parameter int unsigned DEPTH  = SORT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              start,
    input  logic              done,
    output logic [ADDR_W:0]   n_len,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
`ifdef SORT_HOST_PERF_EN
    output logic [15:0]       sort_cycles,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    // Index of the DEPTH-th word; accepting at this address closes the set.
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    sort_host_state_t state_q, state_d;

    logic              armed_q,     armed_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;

    // Pointer bank controls
    logic              wr_clr, wr_inc, rd_clr, rd_inc, n_cap;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              rd_is_last;

    sort_host_ptr #(
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk    (clk),
        .rst    (rst),
        .wr_clr (wr_clr),
        .wr_inc (wr_inc),
        .rd_clr (rd_clr),
        .rd_inc (rd_inc),
        .n_cap  (n_cap),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .n_len  (n_len)
    );

    assign rd_is_last = ({1'b0, rd_ptr} == (n_len - (ADDR_W + 1)'(1)));

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        in_ready  = 1'b0;
        start     = 1'b0;
        mem_sel   = 1'b1;
        mem_addr  = rd_ptr;
        mem_we    = 1'b0;
        mem_wdata = in_data;
        mem_rd    = 1'b0;

        wr_clr = 1'b0;
        wr_inc = 1'b0;
        rd_clr = 1'b0;
        rd_inc = 1'b0;
        n_cap  = 1'b0;

        unique case (state_q)
            StLoad: begin
                in_ready = 1'b1;
                mem_addr = wr_ptr;
                armed_d  = 1'b0;
                if (in_valid) begin
                    mem_we = 1'b1;
                    wr_inc = 1'b1;
                    if (in_last || (wr_ptr == LastIdx)) begin
                        n_cap   = 1'b1;
                        state_d = StSort;
                    end
                end
            end

            StSort: begin
                start   = 1'b1;
                mem_sel = 1'b0;
                // A high done is only trusted once it has been seen low in
                // this sort phase; a leftover preset from the last run is not.
                if (!done) begin
                    armed_d = 1'b1;
                end
                if (done && armed_q) begin
                    rd_clr  = 1'b1;
                    state_d = StRd;
                end
            end

            StRd: begin
                mem_rd  = 1'b1;
                state_d = StCap;
            end

            StCap: begin
                out_data_d  = mem_rdata;
                out_valid_d = 1'b1;
                out_last_d  = rd_is_last;
                state_d     = StOut;
            end

            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        // n_len is kept so the datapath still sees the last count.
                        wr_clr  = 1'b1;
                        state_d = StLoad;
                    end else begin
                        rd_inc  = 1'b1;
                        state_d = StRd;
                    end
                end
            end

            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoad;
            armed_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

`ifdef SORT_HOST_PERF_EN
    // Sort-phase cycle counter: cleared on the edge that enters the sort
    // phase, counts every edge taken while sorting, holds afterwards.
    logic [15:0] sort_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sort_cycles_q <= '0;
        end else if (n_cap) begin
            sort_cycles_q <= '0;
        end else if ((state_q == StSort) && (sort_cycles_q != 16'hFFFF)) begin
            sort_cycles_q <= sort_cycles_q + 16'd1;
        end
    end

    assign sort_cycles = sort_cycles_q;
`endif

endmodule

// File: tb/tb_sort_host_if.sv
// ----------------------------------------------------------------------------
// tb_sort_host_if
//
// Bench for sort_host_if. A memory model and a simple controller model sit
// around the DUT. A transaction-level model (loading flag, accepted count,
// sorted expectation queue) is checked against the DUT on every cycle from a
// negedge compare process; directed scenarios add literal expectations.
// ----------------------------------------------------------------------------
module tb_sort_host_if;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data   = '0;
    logic              in_last   = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              start;
    logic              done      = 1'b0;
    logic [ADDR_W:0]   n_len;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
`ifdef SORT_HOST_PERF_EN
    logic [15:0]       sort_cycles;
`endif

    sort_host_if #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .start       (start),
        .done        (done),
        .n_len       (n_len),
        .mem_sel     (mem_sel),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
`ifdef SORT_HOST_PERF_EN
        .sort_cycles (sort_cycles),
`endif
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Memory and controller models
    // ------------------------------------------------------------------------
    logic [15:0][7:0] mem;
    logic             sort_now = 1'b0;
    int               sort_n   = 0;

    function automatic logic [15:0][7:0] sort_words(input logic [15:0][7:0] m, input int n);
        logic [7:0] t;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n - 1 - i; j++) begin
                if (m[j] > m[j+1]) begin
                    t      = m[j];
                    m[j]   = m[j+1];
                    m[j+1] = t;
                end
            end
        end
        return m;
    endfunction

    always @(posedge clk) begin
        if (sort_now) begin
            mem <= sort_words(mem, sort_n);
        end else if (mem_sel && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_sel && mem_rd) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Transaction-level model and per-cycle compare
    // ------------------------------------------------------------------------
    bit         m_loading = 1'b1;
    int         m_count   = 0;
    int         m_nlen    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    int         start_cycles = 0;

    function automatic void push_sorted(input logic [7:0] v);
        int i;
        i = 0;
        while (i < exp_q.size() && exp_q[i] <= v) i++;
        exp_q.insert(i, v);
    endfunction

    always @(negedge clk) begin
        bit acc;
        if (rst) begin
            m_loading  = 1'b1;
            m_count    = 0;
            m_nlen     = 0;
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(m_loading));
            chk("mem_we", 32'(mem_we), 32'(m_loading && in_valid));
            if (mem_we) begin
                chk("wr_addr", 32'(mem_addr), 32'(m_count));
                chk("wr_data", 32'(mem_wdata), 32'(in_data));
            end
            chk("we_rd_excl", 32'(mem_we & mem_rd), 32'(0));
            chk("mem_sel", 32'(mem_sel), 32'(!start));
            chk("n_len", 32'(n_len), 32'(m_nlen));
            if (start) begin
                chk("out_in_sort", 32'(out_valid), 32'(0));
                start_cycles++;
            end
            if (mem_rd) chk("rd_pending", 32'(exp_q.size() != 0 && !m_loading), 32'(1));
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'(1));
                chk("stall_data", 32'(out_data), 32'(prev_data));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end

            acc = m_loading && in_valid;
            if (acc) begin
                push_sorted(in_data);
                m_count++;
                if (in_last || m_count == DEPTH) begin
                    m_loading = 1'b0;
                    m_nlen    = m_count;
                    sort_n    = m_count;
                end
            end

            if (out_valid && out_ready) begin
                chk("out_extra", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    chk("out_data", 32'(out_data), 32'(exp_q[0]));
                    chk("out_last", 32'(out_last), 32'(exp_q.size() == 1));
                    got_q.push_back(out_data);
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        m_loading = 1'b1;
                        m_count   = 0;
                    end
                end
            end

            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    logic [7:0] vec [16];

    task automatic load(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            in_last  = with_last && (i == n - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Controller: preset drops, sorting takes `delay` cycles, then done rises.
    task automatic ctrl_run(input int delay);
        start_cycles = 0;
        chk("start_on", 32'(start), 32'(1));
        done = 1'b0;
        repeat (delay) begin
            @(posedge clk); #1;
        end
        sort_now = 1'b1;
        @(posedge clk); #1;
        sort_now = 1'b0;
        done     = 1'b1;
        @(posedge clk); #1;
        chk("start_off", 32'(start), 32'(0));
        chk("rd_after_sort", 32'(mem_rd), 32'(1));
        chk("start_window", 32'(start_cycles), 32'(delay + 2));
    endtask

    // Controller whose preset is still high for 3 cycles into the sort phase.
    task automatic ctrl_stale();
        start_cycles = 0;
        chk("stale_start_on", 32'(start), 32'(1));
        repeat (3) begin
            @(posedge clk); #1;
        end
        done     = 1'b0;
        sort_now = 1'b1;
        @(posedge clk); #1;
        sort_now = 1'b0;
        done     = 1'b1;
        @(posedge clk); #1;
        chk("stale_start_off", 32'(start), 32'(0));
        chk("stale_window", 32'(start_cycles), 32'(5));
    endtask

    task automatic drain(input bit toggle);
        logic [3:0] pat;
        int cyc;
        int ph;
        pat = 4'b1001;  // out_ready sequence 1,0,0,1 (bit 0 first)
        cyc = 0;
        ph  = 0;
        while (!(m_loading && exp_q.size() == 0) && cyc < 300) begin
            out_ready = toggle ? pat[ph % 4] : 1'b1;
            ph++;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_left", 32'(exp_q.size()), 32'(0));
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        int g;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_mem_sel", 32'(mem_sel), 32'(1));
        chk("rst_start", 32'(start), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_last", 32'(out_last), 32'(0));
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        chk("rst_mem_rd", 32'(mem_rd), 32'(0));
        chk("rst_n_len", 32'(n_len), 32'(0));

        // 5,3,9,1 with last on the 4th word, done 20 cycles in
        vec[0] = 8'd5; vec[1] = 8'd3; vec[2] = 8'd9; vec[3] = 8'd1;
        got_q.delete();
        load(4, 1'b1);
        chk("t1_n_len", 32'(n_len), 32'(4));
        ctrl_run(20);
        @(posedge clk); #1;
        chk("t1_cap_valid", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        chk("t1_first_valid", 32'(out_valid), 32'(1));
        chk("t1_first_data", 32'(out_data), 32'(1));
        chk("t1_first_last", 32'(out_last), 32'(0));
`ifdef SORT_HOST_PERF_EN
        chk("t1_sort_cycles", 32'(sort_cycles), 32'(22));
`endif
        drain(1'b1);
        chk("t1_count", 32'(got_q.size()), 32'(4));
        if (got_q.size() == 4) begin
            chk("t1_o0", 32'(got_q[0]), 32'(1));
            chk("t1_o1", 32'(got_q[1]), 32'(3));
            chk("t1_o2", 32'(got_q[2]), 32'(5));
            chk("t1_o3", 32'(got_q[3]), 32'(9));
        end

        // 16 words with no in_last; a 17th word must be refused
        for (int i = 0; i < 16; i++) vec[i] = 8'(i * 37 + 11);
        vec[9] = vec[3];
        got_q.delete();
        load(16, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        chk("t2_n_len", 32'(n_len), 32'(16));
        chk("t2_in_ready", 32'(in_ready), 32'(0));
        ctrl_run(3);
        in_valid = 1'b0;
        drain(1'b1);
        chk("t2_count", 32'(got_q.size()), 32'(16));

        // Single word
        vec[0] = 8'h7F;
        got_q.delete();
        load(1, 1'b1);
        chk("t3_n_len", 32'(n_len), 32'(1));
        ctrl_run(3);
        drain(1'b0);
        chk("t3_count", 32'(got_q.size()), 32'(1));
        if (got_q.size() == 1) chk("t3_data", 32'(got_q[0]), 32'(8'h7F));
        chk("t3_in_ready", 32'(in_ready), 32'(1));
        chk("t3_out_valid", 32'(out_valid), 32'(0));

        // Stale done on entry to the sort phase
        done = 1'b1;
        vec[0] = 8'd30; vec[1] = 8'd10; vec[2] = 8'd20;
        got_q.delete();
        load(3, 1'b1);
        ctrl_stale();
        drain(1'b0);
        chk("t4_count", 32'(got_q.size()), 32'(3));
        if (got_q.size() == 3) chk("t4_o0", 32'(got_q[0]), 32'(10));

        // Reset after 2 of 4 outputs
        vec[0] = 8'd4; vec[1] = 8'd2; vec[2] = 8'd8; vec[3] = 8'd6;
        got_q.delete();
        load(4, 1'b1);
        ctrl_run(3);
        out_ready = 1'b1;
        g = 0;
        while (got_q.size() < 2 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk("t5_two_out", 32'(got_q.size()), 32'(2));
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_in_ready", 32'(in_ready), 32'(1));
        chk("t5_start", 32'(start), 32'(0));
        chk("t5_out_valid", 32'(out_valid), 32'(0));
        chk("t5_mem_sel", 32'(mem_sel), 32'(1));
        chk("t5_n_len", 32'(n_len), 32'(0));
`ifdef SORT_HOST_PERF_EN
        chk("t5_sort_cycles", 32'(sort_cycles), 32'(0));
`endif
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
